uart_bus_master: RTL
====================

// Module: uart_bus_master
// PURPOSE
//  Serial-to-bus bridge: host-side initiator for the SoC memory bus, driven over 8N1 UART.
//  Parses command frames from rx_in and issues single-cycle bus reads/writes.
//  Returns results on tx_out. Used for debug access and boot loading before the CPU runs.
// PARAMETERS
//  CLK_DIV   16'd103    clocks per bit minus 1 (bit period = CLK_DIV+1 cycles); same meaning as the peripheral clk_div register
//  TIMEOUT   24'd1000000  idle clocks allowed between bytes of one frame before the parser resyncs
// PORTS
//  clk              in   1   system clock
//  reset_n          in   1   asynchronous, active-low reset
//  rx_in            in   1   serial in from host, idle high
//  tx_out           out  1   serial out to host, idle high
//  sel_out          out  1   bus select, one-cycle pulse per transaction
//  read_out         out  1   bus read strobe, valid with sel_out
//  write_mask_out   out  4   byte write enables, valid with sel_out
//  address_out      out  32  bus address, word aligned ([1:0] forced 0)
//  write_value_out  out  32  bus write data
//  read_value_in    in   32  bus read data, sampled in the sel_out cycle
//  busy_out         out  1   high from first command byte until the last response byte's stop bit ends
// BEHAVIOUR
//  Reset values: tx_out=1, sel_out=0, read_out=0, write_mask_out=0, address_out=0, write_value_out=0, busy_out=0.
//  Parser state=CMD. Receiver is idle.
//  RX: a low level while idle starts a byte. Wait CLK_DIV>>1 clocks, then re-check start.
//   - High at the re-check: glitch, back to idle.
//   - Otherwise take 8 data bits LSB first, then the stop bit, each CLK_DIV+1 clocks apart.
//   - Stop=1 -> byte-valid pulse for 1 clock. Stop=0 -> framing-error pulse for 1 clock, no byte.
//  Frames (multi-byte fields little-endian):
//   - read:  0x52, A0..A3                  -> response D0..D3 (bus read data)
//   - write: 0x57, A0..A3, M, D0..D3       -> response 0x06
//   - M[3:0] becomes write_mask_out. M[7:4] is ignored.
//  Parser states: CMD -> ADDR(x4) -> [MASK -> DATA(x4)] -> BUS -> RESP(1 or 4 bytes) -> CMD.
//   - CMD: 0x52/0x57 go to ADDR and set busy_out. Any other byte sends 0x15 (NAK), then stays in CMD.
//   - BUS: exactly one cycle.
//     read: sel_out=1, read_out=1, write_mask_out=0; read_value_in is latched at the end of that cycle.
//     write: sel_out=1, read_out=0, write_mask_out=M.
//     M=0 still pulses sel_out (no-op write) and is still ACKed.
//   - RESP: load each byte into the TX shifter only after the previous stop bit has completed.
//  TX frame: start 0, 8 data bits LSB first, stop 1; each bit CLK_DIV+1 clocks.
//   - Response bytes are sent back-to-back with no extra idle time.
//  Bytes received during BUS/RESP are discarded.
//  Framing error in any state other than BUS/RESP: parser goes to CMD, partial frame dropped, no response.
//  Timeout: a mid-frame state (ADDR, MASK, DATA) counts clocks since the last byte-valid.
//   - At TIMEOUT, parser goes to CMD silently.
//   - The counter is cleared by every byte-valid and is inactive in CMD.
//  Bus outputs other than sel_out hold their last values between transactions.
//  Reset asserted mid-byte or mid-frame: everything returns to reset values immediately (async).
//   - A partial TX byte is truncated and tx_out goes to 1.
// STRUCTURE
//  Package uart_bridge_pkg: CMD_READ=8'h52, CMD_WRITE=8'h57, RESP_ACK=8'h06, RESP_NAK=8'h15,
//   parser state enum, 8N1 bit-count constant (10).
//  Sub-module uart_byte_rx: start/glitch detect, sampling, byte_valid/frame_err pulses.
//  TX shifter, parser FSM and bus drive stay in uart_bus_master.
// TESTING (bench CLK_DIV=3, TIMEOUT=200; host model drives/samples at 4 clk/bit)
//  1 Write: send 57 10 00 00 00 0F EF BE AD DE
//    -> one sel_out pulse, address_out=0x00000010, write_mask_out=4'hF, write_value_out=0xDEADBEEF,
//       read_out=0; tx returns 0x06.
//  2 Read: send 52 04 00 00 00 with read_value_in=0x12345678
//    -> sel_out=1 and read_out=1 for 1 clk, address_out=0x00000004; tx returns 78 56 34 12 back-to-back.
//  3 Bad command: send 0x41 -> tx returns 0x15, no sel_out.
//    Then a valid read frame completes normally.
//  4 Framing error: send 57 10 00, then a byte with stop=0 -> no response, no sel_out;
//    the following 52 frame is serviced.
//  5 Timeout/glitch: send 52 04, idle 250 clks, then 52 00 00 00 00 -> one read at 0x0, 4 bytes returned.
//    A 1-clk low pulse on rx_in produces no byte.
//  6 Reset: pull reset_n low mid-way through response byte 2
//    -> tx_out=1 and busy_out=0 immediately, no further bytes, sel_out stays 0.

Source files
------------

// File: rtl/uart_bridge_pkg.sv
// uart_bridge_pkg: shared constants and state types for the UART bus bridge
package uart_bridge_pkg;
  localparam logic [7:0] CMD_READ = 8'h52;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] RESP_ACK = 8'h06;
  localparam logic [7:0] RESP_NAK = 8'h15;
  localparam int unsigned FRAME_BITS = 10;
  typedef enum logic [2:0] {ST_CMD, ST_ADDR, ST_MASK, ST_DATA, ST_BUS, ST_RESP} parser_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS} rx_state_t;
  function automatic logic is_cmd(input logic [7:0] b);
    return b == CMD_READ || b == CMD_WRITE;
  endfunction
endpackage

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 receiver with start-glitch rejection and framing-error detection
module uart_byte_rx
  import uart_bridge_pkg::*;
#(
  parameter logic [15:0] CLK_DIV = 16'd103
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_rx,
  output logic       o_valid,
  output logic       o_err,
  output logic [7:0] o_byte
);
  rx_state_t r_state, w_next;
  logic [1:0] r_sync;
  logic [15:0] r_cnt;
  logic [3:0] r_bit;
  logic [7:0] r_data;
  logic r_valid, r_err;
  logic w_rx, w_tick, w_stop;
  assign w_rx = r_sync[1];
  assign w_tick = r_cnt == (r_state == RX_START ? CLK_DIV >> 1 : CLK_DIV);
  assign w_stop = r_bit == 4'(FRAME_BITS - 2);
  assign o_valid = r_valid;
  assign o_err = r_err;
  assign o_byte = r_data;
  // two-flop synchroniser for the host line, idles high
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_sync <= 2'b11;
    else r_sync <= {r_sync[0], i_rx};
  // receiver state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= RX_IDLE;
    else r_state <= w_next;
  // start detect, half-bit glitch re-check, then leave after the stop sample
  always_comb begin
    w_next = r_state;
    if (r_state == RX_IDLE) w_next = w_rx ? RX_IDLE : RX_START;
    else if (w_tick) w_next = r_state == RX_START ? (w_rx ? RX_IDLE : RX_BITS) : (w_stop ? RX_IDLE : RX_BITS);
  end
  // bit timing, LSB-first shift and one-clock result pulses
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_cnt <= '0;
      r_bit <= '0;
      r_data <= '0;
      r_valid <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err <= 1'b0;
      r_cnt <= (r_state == RX_IDLE || w_tick) ? '0 : r_cnt + 16'd1;
      if (r_state != RX_BITS) r_bit <= '0;
      else if (w_tick) begin
        r_bit <= r_bit + 4'd1;
        if (w_stop) begin
          r_valid <= w_rx;
          r_err <= !w_rx;
        end else r_data <= {w_rx, r_data[7:1]};
      end
    end
endmodule

// File: rtl/uart_bus_master.sv
// uart_bus_master: UART command parser driving single-cycle bus reads and writes
module uart_bus_master
  import uart_bridge_pkg::*;
#(
  parameter logic [15:0] CLK_DIV = 16'd103,
  parameter logic [23:0] TIMEOUT = 24'd1000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx_in,
  output logic        tx_out,
  output logic        sel_out,
  output logic        read_out,
  output logic [3:0]  write_mask_out,
  output logic [31:0] address_out,
  output logic [31:0] write_value_out,
  input  logic [31:0] read_value_in,
  output logic        busy_out
);
  parser_state_t r_state, w_next;
  logic w_vb, w_fe;
  logic [7:0] w_byte;
  logic w_frame, w_last, w_to, w_tx_done, w_tx_ready, w_resp_load, w_nak_load, w_tx_load;
  logic [7:0] w_tx_byte;
  logic r_tx_busy;
  logic [15:0] r_tx_cnt;
  logic [3:0] r_tx_bit;
  logic [9:0] r_tx_shift;
  logic [1:0] r_idx;
  logic r_is_write, r_nak_pend, r_sel, r_read;
  logic [31:0] r_addr, r_wdata, r_resp, r_address, r_wvalue;
  logic [3:0] r_mask, r_wmask;
  logic [2:0] r_resp_cnt;
  logic [23:0] r_to_cnt;

  uart_byte_rx #(.CLK_DIV(CLK_DIV)) u_rx (
    .clk(clk), .reset_n(reset_n), .i_rx(rx_in), .o_valid(w_vb), .o_err(w_fe), .o_byte(w_byte)
  );

  assign w_frame = r_state == ST_ADDR || r_state == ST_MASK || r_state == ST_DATA;
  assign w_last = r_idx == 2'd3;
  assign w_to = w_frame && r_to_cnt >= TIMEOUT;
  assign w_tx_done = r_tx_busy && r_tx_cnt == CLK_DIV && r_tx_bit == 4'(FRAME_BITS - 1);
  assign w_tx_ready = !r_tx_busy || w_tx_done;
  assign w_resp_load = r_state == ST_RESP && !r_sel && r_resp_cnt != 3'd0 && w_tx_ready;
  assign w_nak_load = r_nak_pend && w_tx_ready && !w_resp_load;
  assign w_tx_load = w_resp_load || w_nak_load;
  assign w_tx_byte = w_resp_load ? r_resp[7:0] : RESP_NAK;
  assign tx_out = r_tx_busy ? r_tx_shift[0] : 1'b1;
  assign sel_out = r_sel;
  assign read_out = r_read;
  assign write_mask_out = r_wmask;
  assign address_out = r_address;
  assign write_value_out = r_wvalue;
  assign busy_out = r_state != ST_CMD;

  // parser state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= ST_CMD;
    else r_state <= w_next;
  // frame sequencing; framing errors and inter-byte timeouts resync to CMD
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_CMD:  if (w_vb && is_cmd(w_byte)) w_next = ST_ADDR;
      ST_ADDR: w_next = w_fe ? ST_CMD : w_vb ? (w_last ? (r_is_write ? ST_MASK : ST_BUS) : ST_ADDR) : w_to ? ST_CMD : ST_ADDR;
      ST_MASK: w_next = w_fe ? ST_CMD : w_vb ? ST_DATA : w_to ? ST_CMD : ST_MASK;
      ST_DATA: w_next = w_fe ? ST_CMD : w_vb ? (w_last ? ST_BUS : ST_DATA) : w_to ? ST_CMD : ST_DATA;
      ST_BUS:  w_next = ST_RESP;
      default: if (r_resp_cnt == 3'd0 && w_tx_ready) w_next = ST_CMD;
    endcase
  end
  // field capture, bus drive and response queue; sel_out follows BUS by one register stage
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_to_cnt <= '0;
      r_idx <= '0;
      r_is_write <= 1'b0;
      r_addr <= '0;
      r_mask <= '0;
      r_wdata <= '0;
      r_nak_pend <= 1'b0;
      r_sel <= 1'b0;
      r_read <= 1'b0;
      r_wmask <= '0;
      r_address <= '0;
      r_wvalue <= '0;
      r_resp <= '0;
      r_resp_cnt <= '0;
    end else begin
      r_to_cnt <= (w_frame && !w_vb) ? r_to_cnt + 24'd1 : '0;
      if (r_state == ST_CMD) r_idx <= '0;
      else if (w_vb && (r_state == ST_ADDR || r_state == ST_DATA)) r_idx <= r_idx + 2'd1;
      if (w_vb && r_state == ST_CMD) r_is_write <= w_byte == CMD_WRITE;
      if (w_vb && r_state == ST_ADDR) r_addr <= {w_byte, r_addr[31:8]};
      if (w_vb && r_state == ST_MASK) r_mask <= w_byte[3:0];
      if (w_vb && r_state == ST_DATA) r_wdata <= {w_byte, r_wdata[31:8]};
      r_nak_pend <= (w_vb && r_state == ST_CMD && !is_cmd(w_byte)) || (r_nak_pend && !w_nak_load);
      r_sel <= r_state == ST_BUS;
      if (r_state == ST_BUS) begin
        r_address <= r_addr & ~32'h3;
        r_read <= !r_is_write;
        r_wmask <= r_is_write ? r_mask : 4'h0;
        if (r_is_write) r_wvalue <= r_wdata;
        r_resp <= {24'h0, RESP_ACK};
        r_resp_cnt <= r_is_write ? 3'd1 : 3'd4;
      end else if (r_sel && r_read) r_resp <= read_value_in;
      else if (w_resp_load) begin
        r_resp <= r_resp >> 8;
        r_resp_cnt <= r_resp_cnt - 3'd1;
      end
    end
  // 8N1 transmitter; a new byte may load on the last clock of the previous stop bit
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_tx_busy <= 1'b0;
      r_tx_cnt <= '0;
      r_tx_bit <= '0;
      r_tx_shift <= '1;
    end else if (w_tx_load) begin
      r_tx_busy <= 1'b1;
      r_tx_cnt <= '0;
      r_tx_bit <= '0;
      r_tx_shift <= {1'b1, w_tx_byte, 1'b0};
    end else if (r_tx_busy) begin
      r_tx_cnt <= r_tx_cnt == CLK_DIV ? '0 : r_tx_cnt + 16'd1;
      if (r_tx_cnt == CLK_DIV) begin
        r_tx_shift <= {1'b1, r_tx_shift[9:1]};
        r_tx_bit <= r_tx_bit + 4'd1;
        r_tx_busy <= !w_tx_done;
      end
    end
endmodule
